// File: rtl/mbgd_pkg.sv
// Shared FSM state type and width helpers for the chunked dot-product sequencer.
package mbgd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mbgd_state_e;

  // Lane product width: full 2*DW product plus log2(N) headroom bits.
  function automatic int lane_prod_w(input int dw, input int n_bit);
    return 2 * dw + n_bit;
  endfunction

  // Accumulator width: a lane-sum per chunk, up to 2**CW - 1 chunks.
  function automatic int acc_w(input int dw, input int n_bit, input int cw);
    return 2 * dw + n_bit + cw;
  endfunction

endpackage

// File: rtl/mbgd_dot_seq_ctrl_if.sv
// Operand, multiplier and result handshake bundle for mbgd_dot_seq_ctrl.
interface mbgd_dot_seq_ctrl_if #(
  parameter int N     = 8,
  parameter int N_bit = 3,
  parameter int DW    = 8,
  parameter int CW    = 4
) ();
  import mbgd_pkg::*;

  localparam int LPW   = lane_prod_w(DW, N_bit);
  localparam int ACC_W = acc_w(DW, N_bit, CW);

  logic              in_valid;
  logic              in_ready;
  logic [DW*N-1:0]   in_a;
  logic [DW*N-1:0]   in_b;

  logic              mult_en;
  logic [DW*N-1:0]   mult_a;
  logic [DW*N-1:0]   mult_b;
  logic [LPW*N-1:0]  lane_prod;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready,
    output mult_en, mult_a, mult_b,
    input  lane_prod,
    output out_valid,
    input  out_ready,
    output result
  );

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready,
    input  mult_en, mult_a, mult_b,
    output lane_prod,
    input  out_valid,
    output out_ready,
    input  result
  );

endinterface

// File: rtl/mbgd_lane_adder_tree.sv
// Balanced combinational adder tree summing N unsigned lanes (N a power of two).
module mbgd_lane_adder_tree #(
  parameter int N     = 8,
  parameter int N_bit = 3,
  parameter int IW    = 16
) (
  input  logic [N*IW-1:0]       lanes_i,
  output logic [IW+N_bit-1:0]   sum_o
);
  localparam int OW = IW + N_bit;

  // Level l holds N>>l partial sums; level N_bit is the single root.
  for (genvar l = 0; l <= N_bit; l++) begin : g_lvl
    logic [OW-1:0] v [N>>l];
    if (l == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_i
        assign v[i] = OW'(lanes_i[i*IW +: IW]);
      end
    end else begin : g_add
      for (genvar i = 0; i < (N >> l); i++) begin : g_i
        assign v[i] = g_lvl[l-1].v[2*i] + g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign sum_o = g_lvl[N_bit].v[0];

endmodule

// File: rtl/mbgd_dot_seq_ctrl.sv
// Sequencer for a chunked unsigned dot product using an external registered lane multiplier.
// Define MBGD_DOT_SEQ_ABORT_EN to add an abort input that cancels RUN/DRAIN back to IDLE.
module mbgd_dot_seq_ctrl
  import mbgd_pkg::*;
#(
  parameter int N     = 8,
  parameter int N_bit = 3,
  parameter int DW    = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] num_chunks,
`ifdef MBGD_DOT_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  mbgd_dot_seq_ctrl_if.slave bus
);
  localparam int IW    = 2 * DW;
  localparam int LPW   = lane_prod_w(DW, N_bit);
  localparam int ACC_W = acc_w(DW, N_bit, CW);

  mbgd_state_e        state_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      num_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic               prod_pending_q;
  logic [N*IW-1:0]    lane_trunc;
  logic [N*N_bit-1:0] lane_hi_unused;
  logic [LPW-1:0]     lane_sum;
  logic               abort_req;
  logic               xfer;

`ifdef MBGD_DOT_SEQ_ABORT_EN
  assign abort_req = abort && ((state_q == RUN) || (state_q == DRAIN));
`else
  assign abort_req = 1'b0;
`endif

  // Each returned lane is cut to its 2*DW product bits before summation.
  always_comb begin
    lane_trunc     = '0;
    lane_hi_unused = '0;
    for (int i = 0; i < N; i++) begin
      lane_trunc[i*IW +: IW]            = bus.lane_prod[i*LPW +: IW];
      lane_hi_unused[i*N_bit +: N_bit]  = bus.lane_prod[i*LPW+IW +: N_bit];
    end
  end

  mbgd_lane_adder_tree #(
    .N     (N),
    .N_bit (N_bit),
    .IW    (IW)
  ) u_tree (
    .lanes_i (lane_trunc),
    .sum_o   (lane_sum)
  );

  // Reset and abort close the operand port in the same cycle so no product is launched.
  assign bus.in_ready  = (state_q == RUN) && !reset && !abort_req;
  assign xfer          = bus.in_valid && bus.in_ready;
  assign bus.mult_en   = xfer;
  assign bus.mult_a    = bus.in_a;
  assign bus.mult_b    = bus.in_b;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = acc_q;
  assign busy          = (state_q != IDLE);

  assign acc_d = prod_pending_q ? (acc_q + ACC_W'(lane_sum)) : acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      num_q          <= '0;
      acc_q          <= '0;
      prod_pending_q <= 1'b0;
    end else begin
      prod_pending_q <= xfer;
      acc_q          <= acc_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            num_q   <= num_chunks;
            state_q <= (num_chunks == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort_req) begin
            acc_q   <= '0;
            state_q <= IDLE;
          end else if (xfer) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == (num_q - CW'(1))) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The last chunk's product lands here via acc_d.
          if (abort_req) begin
            acc_q   <= '0;
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbgd_dot_seq_ctrl.sv
// Self-checking bench for mbgd_dot_seq_ctrl with a registered lane multiplier model.
`timescale 1ns/1ps
module tb_mbgd_dot_seq_ctrl;
  localparam int N     = 8;
  localparam int N_bit = 3;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int LPW   = 2*DW + N_bit;
  localparam int ACC_W = 2*DW + N_bit + CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_chunks;
  logic          busy;
`ifdef MBGD_DOT_SEQ_ABORT_EN
  logic          abort;
`endif

  mbgd_dot_seq_ctrl_if #(.N(N), .N_bit(N_bit), .DW(DW), .CW(CW)) bus ();

  mbgd_dot_seq_ctrl #(.N(N), .N_bit(N_bit), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_chunks (num_chunks),
`ifdef MBGD_DOT_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Lane multiplier: registered products one cycle after mult_en, junk in the headroom bits
  // and on idle cycles.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.mult_en)
        bus.lane_prod[i*LPW +: LPW] <= {N_bit'($urandom_range(0, 7)),
          (2*DW)'((2*DW)'(bus.mult_a[i*DW +: DW]) * (2*DW)'(bus.mult_b[i*DW +: DW]))};
      else
        bus.lane_prod[i*LPW +: LPW] <= LPW'($urandom);
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  logic [DW*N-1:0] va [16];
  logic [DW*N-1:0] vb [16];

  logic [ACC_W-1:0] o_res, o_res_last;
  int   o_mults, o_last, o_lat, o_done, o_vcnt;
  logic o_busy_after, o_ov_after;
  bit   o_timeout;

  function automatic longint ref_dot(input int nch);
    longint s = 0;
    for (int c = 0; c < nch; c++)
      for (int i = 0; i < N; i++)
        s += longint'(va[c][i*DW +: DW]) * longint'(vb[c][i*DW +: DW]);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int c = 0; c < 16; c++)
      for (int i = 0; i < N; i++) begin
        va[c][i*DW +: DW] = a;
        vb[c][i*DW +: DW] = b;
      end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < 16; c++)
      for (int i = 0; i < N; i++) begin
        va[c][i*DW +: DW] = DW'($urandom);
        vb[c][i*DW +: DW] = DW'($urandom);
      end
  endtask

  // Drives one whole transaction and records what was observed; gap<0 means random gaps.
  task automatic run_txn(input int nch, input int gap, input int hold, input bit poke);
    int cyc, idx, wait_n;
    cyc = 0; idx = 0; wait_n = 0;
    o_mults = 0; o_last = -1; o_timeout = 0; o_vcnt = 0;
    start = 1'b1; num_chunks = CW'(nch); bus.out_ready = 1'b0;
    step();
    start = 1'b0;
    while (!bus.out_valid) begin
      if (cyc > 400) begin o_timeout = 1; break; end
      if (idx < nch && wait_n == 0) begin
        bus.in_valid = 1'b1; bus.in_a = va[idx]; bus.in_b = vb[idx];
      end else begin
        bus.in_valid = (idx >= nch) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in_a = {$urandom, $urandom}; bus.in_b = {$urandom, $urandom};
        if (wait_n > 0) wait_n--;
      end
      #1;
      if (bus.mult_en) o_mults++;
      if (bus.in_valid && bus.in_ready) begin
        idx++; o_last = cyc;
        wait_n = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.in_valid = 1'b0;
    o_done = cyc; o_res = bus.result; o_res_last = bus.result; o_lat = cyc - o_last;
    for (int h = 0; h < hold; h++) begin
      start = poke && (h == 0); num_chunks = CW'(5);
      bus.in_valid = 1'($urandom_range(0, 1));
      step();
      if (bus.out_valid) o_vcnt++;
      o_res_last = bus.result;
    end
    start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    o_busy_after = busy; o_ov_after = bus.out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b1; start = 1'b1;
    repeat (3) step();
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_vec++; if (bus.mult_en !== 1'b0) begin n_fail++; $display("FAIL reset_mult_en: got %b want 0", bus.mult_en); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: got %0d want 0", bus.result); end
    reset = 1'b0; bus.in_valid = 1'b0; start = 1'b0;
    step();
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    fill_const(8'd1, 8'd2);
    run_txn(3, 0, 0, 0);
    n_vec++; if (o_timeout) begin n_fail++; $display("FAIL basic_timeout: no out_valid within budget"); end
    n_vec++; if (o_res !== ACC_W'(48)) begin n_fail++; $display("FAIL basic_result: got %0d want 48", o_res); end
    n_vec++; if (o_mults != 3) begin n_fail++; $display("FAIL basic_mult_en: got %0d pulses want 3", o_mults); end
    n_vec++; if (o_last != 2) begin n_fail++; $display("FAIL basic_consecutive: last transfer cycle %0d want 2", o_last); end
    n_vec++; if (o_lat != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", o_lat); end
    n_vec++; if (o_busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: busy %b want 0", o_busy_after); end
  endtask

  task automatic test_max();
    fill_const(8'd255, 8'd255);
    run_txn(1, 0, 1, 0);
    n_vec++; if (o_res !== ACC_W'(520200)) begin n_fail++; $display("FAIL max_result: got %0d want 520200", o_res); end
    n_vec++; if (o_lat != 2) begin n_fail++; $display("FAIL max_latency: got %0d want 2", o_lat); end
  endtask

  task automatic test_stall();
    longint exp;
    fill_rand();
    exp = ref_dot(2);
    run_txn(2, 3, 4, 1);
    n_vec++; if (o_res !== ACC_W'(exp)) begin n_fail++; $display("FAIL stall_result: got %0d want %0d", o_res, exp); end
    n_vec++; if (o_vcnt != 4) begin n_fail++; $display("FAIL stall_out_valid_held: got %0d cycles want 4", o_vcnt); end
    n_vec++; if (o_res_last !== ACC_W'(exp)) begin n_fail++; $display("FAIL stall_result_held: got %0d want %0d", o_res_last, exp); end
    n_vec++; if (o_lat != 2) begin n_fail++; $display("FAIL stall_latency: got %0d want 2", o_lat); end
    n_vec++; if (o_busy_after !== 1'b0 || o_ov_after !== 1'b0) begin n_fail++;
      $display("FAIL stall_release: busy %b out_valid %b want 0 0", o_busy_after, o_ov_after); end
  endtask

  task automatic test_zero();
    fill_rand();
    run_txn(0, 0, 1, 0);
    n_vec++; if (o_done != 0) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 0", o_done); end
    n_vec++; if (o_res !== '0) begin n_fail++; $display("FAIL zero_result: got %0d want 0", o_res); end
    n_vec++; if (o_mults != 0) begin n_fail++; $display("FAIL zero_mult_en: got %0d want 0", o_mults); end
  endtask

  task automatic test_reset_mid();
    fill_rand();
    start = 1'b1; num_chunks = CW'(4);
    step();
    start = 1'b0; bus.in_valid = 1'b1; bus.in_a = va[0]; bus.in_b = vb[0];
    step();
    reset = 1'b1; start = 1'b1; bus.out_ready = 1'b1; bus.in_a = va[1]; bus.in_b = vb[1];
    #1;
    n_vec++; if (bus.mult_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_mult_en: got %b want 0", bus.mult_en); end
    step();
    n_vec++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_state: busy %b out_valid %b want 0 0", busy, bus.out_valid); end
    reset = 1'b0; start = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    step();
    n_vec++; if (bus.result !== '0) begin n_fail++; $display("FAIL rstmid_residue: got %0d want 0", bus.result); end
    fill_const(8'd1, 8'd1);
    run_txn(1, 0, 0, 0);
    n_vec++; if (o_res !== ACC_W'(8)) begin n_fail++; $display("FAIL rstmid_result: got %0d want 8", o_res); end
  endtask

  task automatic test_back_to_back();
    longint exp;
    fill_rand();
    exp = ref_dot(15);
    run_txn(15, 0, 0, 0);
    n_vec++; if (o_res !== ACC_W'(exp)) begin n_fail++; $display("FAIL b2b_result: got %0d want %0d", o_res, exp); end
    n_vec++; if (o_last != 14) begin n_fail++; $display("FAIL b2b_rate: last transfer cycle %0d want 14", o_last); end
  endtask

  task automatic test_random();
    longint exp;
    int nch, hold;
    for (int t = 0; t < 12; t++) begin
      fill_rand();
      nch  = int'($urandom_range(0, 15));
      hold = int'($urandom_range(0, 3));
      exp  = ref_dot(nch);
      run_txn(nch, -1, hold, 1'($urandom_range(0, 1)));
      n_vec++; if (o_timeout) begin n_fail++; $display("FAIL rand_timeout: txn %0d", t); end
      n_vec++; if (o_res !== ACC_W'(exp)) begin n_fail++; $display("FAIL rand_result: txn %0d got %0d want %0d", t, o_res, exp); end
      n_vec++; if (o_mults != nch) begin n_fail++; $display("FAIL rand_mult_en: txn %0d got %0d want %0d", t, o_mults, nch); end
      n_vec++; if (nch > 0 && o_lat != 2) begin n_fail++; $display("FAIL rand_latency: txn %0d got %0d want 2", t, o_lat); end
      n_vec++; if (o_vcnt != hold || o_res_last !== ACC_W'(exp)) begin n_fail++;
        $display("FAIL rand_hold: txn %0d valid %0d/%0d result %0d want %0d", t, o_vcnt, hold, o_res_last, exp); end
      n_vec++; if (o_busy_after !== 1'b0) begin n_fail++; $display("FAIL rand_idle_after: txn %0d busy %b", t, o_busy_after); end
    end
  endtask

`ifdef MBGD_DOT_SEQ_ABORT_EN
  task automatic test_abort();
    int ov_seen;
    fill_rand();
    start = 1'b1; num_chunks = CW'(4);
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1; bus.in_a = va[k]; bus.in_b = vb[k];
      step();
    end
    bus.in_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    ov_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.out_valid) ov_seen++;
      step();
    end
    n_vec++; if (ov_seen != 0) begin n_fail++; $display("FAIL abort_out_valid: seen %0d want 0", ov_seen); end
    n_vec++; if (bus.result !== '0) begin n_fail++; $display("FAIL abort_acc_clear: got %0d want 0", bus.result); end
    fill_const(8'd1, 8'd1);
    run_txn(1, 0, 0, 0);
    n_vec++; if (o_res !== ACC_W'(8)) begin n_fail++; $display("FAIL abort_next_result: got %0d want 8", o_res); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; num_chunks = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
`ifdef MBGD_DOT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_max();
    test_stall();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef MBGD_DOT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
